// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding the fetch/decode pipeline register.
// Owns the PC and keeps at most one instruction-memory request outstanding.
// One returned word is buffered and offered downstream as pc_out/ins_out/stop_f.
// The offered word can be held by stall, flushed by redirect, and a halt opcode stops fetch.
//
// Ports:
//   clk, rstd            clock (rising edge), asynchronous active-high reset
//   stall                downstream cannot accept the offered word this cycle
//   redirect/redirect_pc flush the buffer and refetch from redirect_pc
//   imem_req/imem_addr   single-outstanding fetch request, word aligned
//   imem_ack/imem_rdata  returned instruction word (at least one cycle after req)
//   pc_out/ins_out       offered PC and word (NOP_INS when nothing is offered)
//   stop_f               01 valid, 10 bubble, 00 halted
//
// Optional feature macro: IF_STAGE_STAT_EN
//   Adds stat_fetched (words consumed) and stat_bubble (non-halted bubble cycles).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'hdc00_0000,
    parameter logic [5:0]  HALT_OPC = 6'h3f
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic [1:0]  stop_f
`ifdef IF_STAGE_STAT_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_bubble
`endif
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic            drop_q, drop_d;
    logic            buf_v_q, buf_v_d;
    logic [XLEN-1:0] buf_ins_q, buf_ins_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic            halted_q, halted_d;

    logic            consume;
    logic            issue;
    logic            ack_v;

    // State register
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
            buf_v_q   <= 1'b0;
            buf_ins_q <= NOP_INS;
            buf_pc_q  <= RESET_PC;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            buf_v_q   <= buf_v_d;
            buf_ins_q <= buf_ins_d;
            buf_pc_q  <= buf_pc_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state: redirect beats consume/return/issue; halted freezes everything
    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        buf_v_d   = buf_v_q;
        buf_ins_d = buf_ins_q;
        buf_pc_d  = buf_pc_q;
        halted_d  = halted_q;

        consume = buf_v_q & ~stall & ~redirect & ~halted_q;
        // A slot opens either when the buffer is empty or when it drains this edge
        issue   = ~halted_q & ~pend_q & (~buf_v_q | consume) & ~redirect;
        ack_v   = imem_ack & pend_q;

        if (!halted_q) begin
            if (redirect) begin
                buf_v_d = 1'b0;
                pc_d    = redirect_pc;
                if (ack_v) begin
                    pend_d = 1'b0;
                    drop_d = 1'b0;
                end else if (pend_q) begin
                    drop_d = 1'b1;
                end
            end else begin
                if (consume) begin
                    buf_v_d = 1'b0;
                    if (buf_ins_q[31:26] == HALT_OPC) begin
                        halted_d = 1'b1;
                    end
                end
                if (ack_v) begin
                    pend_d = 1'b0;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        buf_ins_d = imem_rdata;
                        buf_pc_d  = pc_q;
                        buf_v_d   = 1'b1;
                        pc_d      = pc_q + XLEN'(4);
                    end
                end
                if (issue) begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    // Request is masked while reset is held so nothing is accepted during reset
    assign imem_req  = issue & ~rstd;
    assign imem_addr = pc_q;
    assign ins_out   = buf_v_q ? buf_ins_q : NOP_INS;
    assign pc_out    = buf_pc_q;
    assign stop_f    = halted_q ? 2'b00 : ((buf_v_q & ~stall) ? 2'b01 : 2'b10);

`ifdef IF_STAGE_STAT_EN
    logic [XLEN-1:0] stat_fetched_q, stat_fetched_d;
    logic [XLEN-1:0] stat_bubble_q, stat_bubble_d;

    // Event counters, free-running with natural wrap
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            stat_fetched_q <= '0;
            stat_bubble_q  <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_bubble_q  <= stat_bubble_d;
        end
    end

    always_comb begin
        stat_fetched_d = stat_fetched_q;
        stat_bubble_d  = stat_bubble_q;
        if (consume) begin
            stat_fetched_d = stat_fetched_q + XLEN'(1);
        end
        if (!halted_q && (stop_f == 2'b10)) begin
            stat_bubble_d = stat_bubble_q + XLEN'(1);
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_bubble  = stat_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: random-latency memory, random stall/redirect/reset,
// expected delivery stream kept in a queue and checked by an independent monitor.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INS   = 32'hdc00_0000;
    localparam logic [31:0] HALT_WORD = 32'hfc00_0000;

    logic        clk;
    logic        rstd;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic [1:0]  stop_f;

    if_stage dut (
        .clk         (clk),
        .rstd        (rstd),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .ins_out     (ins_out),
        .stop_f      (stop_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Program image, aliased every 1 KiB
    logic [31:0] mem_arr [0:255];
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_arr[a[9:2]];
    endfunction

    // Reference model: the in-order stream of PCs the stage should deliver
    logic [31:0] exp_q[$];
    logic [31:0] next_fetch;
    bit          model_halted;
    int          deliveries;
    int          idle;

    // Memory model state
    bit          req_seen;
    logic [31:0] req_addr;
    bit          mem_busy;
    bit          ack_prev;
    bit          stale_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_fixed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: memory response first, then control inputs and model update
    task automatic drive(input bit st, input bit rd, input logic [31:0] tgt, input bit rs);
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        if (ack_prev) mem_busy = 1'b0;
        ack_prev = 1'b0;
        if (rs) begin
            if (mem_busy || req_seen) stale_pending = 1'b1;
            mem_busy = 1'b0;
            req_seen = 1'b0;
        end else begin
            if (req_seen) begin
                mem_busy = 1'b1;
                mem_addr = req_addr;
                mem_cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
            end
            req_seen = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                    ack_prev   = 1'b1;
                end
            end else if (stale_pending && rstd) begin
                // Late answer to a request that reset abandoned
                imem_ack      = 1'b1;
                imem_rdata    = HALT_WORD;
                stale_pending = 1'b0;
            end
        end
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        rstd        = rs;
        if (rs) begin
            exp_q.delete();
            next_fetch   = RESET_PC;
            model_halted = 1'b0;
        end else if (rd && !model_halted) begin
            exp_q.delete();
            next_fetch = tgt;
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_fetch);
            next_fetch = next_fetch + 32'd4;
        end
    endtask

    // Memory-side protocol observer
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req) begin
                chk("req_single_outstanding", 32'(mem_busy), 32'd0);
                chk("req_addr_aligned", 32'(imem_addr[1:0]), 32'd0);
            end
            req_seen = imem_req;
            req_addr = imem_addr;
        end
    end

    // Scoreboard monitor
    initial begin
        logic [31:0] e;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (rstd) begin
                chk("reset_stop_f", 32'(stop_f), 32'd2);
                chk("reset_req", 32'(imem_req), 32'd0);
                chk("reset_pc_out", pc_out, RESET_PC);
                chk("reset_ins_out", ins_out, NOP_INS);
                idle = 0;
            end else begin
                chk("stop_f_legal", 32'(stop_f == 2'b11), 32'd0);
                if (model_halted) begin
                    chk("halted_stop_f", 32'(stop_f), 32'd0);
                    chk("halted_req", 32'(imem_req), 32'd0);
                    idle = 0;
                end else if (stop_f == 2'b01 && !redirect) begin
                    if (exp_q.size() == 0) begin
                        chk("delivery_expected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        w = mem_word(e);
                        chk("pc_out", pc_out, e);
                        chk("ins_out", ins_out, w);
                        if (w[31:26] == 6'h3f) model_halted = 1'b1;
                        deliveries++;
                    end
                    idle = 0;
                end else begin
                    chk("stop_f_not_halted", 32'(stop_f == 2'b00), 32'd0);
                    idle++;
                    if (idle > 200) begin
                        chk("progress_timeout", 32'(idle), 32'd200);
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int halt_cnt;
        bit st;
        bit rd;
        bit rs;
        logic [31:0] tgt;

        for (int i = 0; i < 256; i++) mem_arr[i] = {6'h08, 26'($urandom())};
        mem_arr[0]   = 32'h2001_0005;
        mem_arr[1]   = 32'h2002_0007;
        mem_arr[2]   = 32'h2003_0009;
        mem_arr[3]   = HALT_WORD;
        mem_arr[200] = HALT_WORD;

        rstd = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        next_fetch = RESET_PC; model_halted = 1'b0;
        deliveries = 0; idle = 0;
        req_seen = 1'b0; mem_busy = 1'b0; ack_prev = 1'b0; stale_pending = 1'b0;
        mem_cnt = 0; mem_addr = '0; lat_fixed = 1;

        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);

        // Fetch from reset, then stall on the first buffered word
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t1_first_req", 32'(imem_req), 32'd1);
        chk("t1_first_addr", imem_addr, 32'h0);
        drive(0, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, '0, 0);
            @(negedge clk);
            chk("t2_stall_stop_f", 32'(stop_f), 32'd2);
            chk("t2_stall_req", 32'(imem_req), 32'd0);
            chk("t2_stall_ins", ins_out, 32'h2001_0005);
        end
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t2_release_stop_f", 32'(stop_f), 32'd1);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t1_gap_stop_f", 32'(stop_f), 32'd2);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t1_second_pc", pc_out, 32'h4);

        // Redirect while the request to 0x8 is outstanding (ack 3 cycles out)
        lat_fixed = 3;
        drive(0, 1, 32'h100, 0);
        lat_fixed = 1;
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t3_wait_req", 32'(imem_req), 32'd0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t3_drop_cycle_req", 32'(imem_req), 32'd0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t3_new_req", 32'(imem_req), 32'd1);
        chk("t3_new_addr", imem_addr, 32'h100);
        drive(0, 0, '0, 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t3_first_pc", pc_out, 32'h100);

        // Redirect coinciding with the ack
        drive(0, 1, 32'h0, 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h0);

        // Run into the halt word at 0xc, then poke with redirect and stall
        for (int i = 0; i < 40 && !model_halted; i++) drive(0, 0, '0, 0);
        chk("t5_halt_reached", 32'(model_halted), 32'd1);
        for (int i = 0; i < 4; i++) drive(i[0], 1, 32'h40, 0);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t5_resume_stop_f", 32'(stop_f), 32'd2);
        chk("t5_resume_addr", imem_addr, RESET_PC);

        // Reset while that request is outstanding; the late ack must be ignored
        lat_fixed = 3;
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        lat_fixed = 2;
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t6_stale_cycle_stop_f", 32'(stop_f), 32'd2);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, RESET_PC);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t6_stale_ignored", 32'(stop_f), 32'd2);

        // Random traffic
        lat_fixed = 0;
        halt_cnt  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            halt_cnt = model_halted ? halt_cnt + 1 : 0;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 299) == 0) || (halt_cnt > 6);
            if ($urandom_range(0, 9) == 0) tgt = 32'hffff_fff8;
            else tgt = {22'd0, 8'($urandom()), 2'b00};
            if (rs) rd = 1'b0;
            drive(st, rd, tgt, rs);
        end
        for (int i = 0; i < 10; i++) drive(0, 0, '0, 0);
        chk("min_deliveries", 32'(deliveries >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
